buff2mac: RTL and testbench

Transmit-side drain stage: reads Ethernet frames from the shared dual-port frame buffer and streams them to the 10G MAC transmit interface. Each committed frame in the buffer is one header word holding the byte length in bits [47:32], followed by ceil(len/8) data words. The upstream receive stage publishes its commit pointer `committed_prod`. This block returns `committed_cons`, which is the upstream stage's fullness reference, and uses it to free buffer space.

---
 rtl/buff2mac.sv | 135 +++++++++++++
 tb/tb_buff2mac.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/buff2mac.sv
// buff2mac: drains committed frames from the shared frame buffer to the 10G MAC tx interface
module buff2mac #(
  parameter int          BW      = 10,
  parameter logic [15:0] MAX_LEN = 16'd9216
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [BW-1:0] rd_addr,
  input  logic [63:0]   rd_data,
  input  logic [BW-1:0] committed_prod,
  output logic [BW-1:0] committed_cons,
  output logic [63:0]   tx_data,
  output logic [7:0]    tx_data_valid,
  output logic          tx_start,
  input  logic          tx_ack,
  output logic          activity,
  output logic [15:0]   sent_pkts,
  output logic [15:0]   bad_len_pkts
);
  typedef enum logic [2:0] {IDLE, HDR_WAIT, HDR, FIRST, START, STREAM, COMMIT} state_t;
  state_t        r_state, w_next;
  logic [BW-1:0] r_rd_addr, r_cons;
  logic [63:0]   r_tx_data, r_hold;
  logic [7:0]    r_valid;
  logic          r_start, r_act, r_first;
  logic [15:0]   r_sent, r_bad;
  logic [2:0]    r_rem;
  logic [12:0]   r_nw, r_cnt;
  logic [15:0]   w_len;
  logic [12:0]   w_hdr_nw, w_idx;
  logic          w_bad;
  logic [7:0]    w_last_mask, w_mask;
  assign w_len       = rd_data[47:32];
  assign w_hdr_nw    = w_len[15:3] + {12'd0, |w_len[2:0]};
  assign w_bad       = (w_len == 16'd0) || (w_len > MAX_LEN);
  assign w_last_mask = (r_rem == 3'd0) ? 8'hFF : (8'd1 << r_rem) - 8'd1;
  assign w_idx       = (r_state == START) ? 13'd2 : r_cnt + 13'd1;
  assign w_mask      = (w_idx == r_nw) ? w_last_mask : 8'hFF;
  assign rd_addr        = r_rd_addr;
  assign committed_cons = r_cons;
  assign tx_data        = r_tx_data;
  assign tx_data_valid  = r_valid;
  assign tx_start       = r_start;
  assign activity       = r_act;
  assign sent_pkts      = r_sent;
  assign bad_len_pkts   = r_bad;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // next-state: the last word presented in START/STREAM leads to COMMIT
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = (committed_prod != r_cons) ? HDR_WAIT : IDLE;
      HDR_WAIT: w_next = HDR;
      HDR:      w_next = w_bad ? IDLE : FIRST;
      FIRST:    w_next = START;
      START:    w_next = !tx_ack ? START : (r_nw <= 13'd2) ? COMMIT : STREAM;
      STREAM:   w_next = (w_idx == r_nw) ? COMMIT : STREAM;
      COMMIT:   w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end
  // word 2 lands while waiting for ack, so it is parked in r_hold and the
  // address runs one word ahead to keep the stream gapless after the ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr <= '0;
      r_cons    <= '0;
      r_tx_data <= '0;
      r_hold    <= '0;
      r_valid   <= '0;
      r_start   <= 1'b0;
      r_act     <= 1'b0;
      r_first   <= 1'b0;
      r_sent    <= '0;
      r_bad     <= '0;
      r_rem     <= '0;
      r_nw      <= '0;
      r_cnt     <= '0;
    end else begin
      r_act   <= 1'b0;
      r_first <= (r_state == FIRST);
      if (r_first) r_hold <= rd_data;
      case (r_state)
        IDLE: if (committed_prod != r_cons) r_rd_addr <= r_cons;
        HDR_WAIT: r_rd_addr <= r_cons + BW'(1);
        HDR: begin
          r_nw  <= w_hdr_nw;
          r_rem <= w_len[2:0];
          if (w_len == 16'd0) begin
            r_cons <= r_cons + BW'(1);
            r_bad  <= r_bad + 16'd1;
          end else if (w_len > MAX_LEN) begin
            r_cons <= committed_prod;
            r_bad  <= r_bad + 16'd1;
          end else r_rd_addr <= r_cons + BW'(2);
        end
        FIRST: begin
          r_tx_data <= rd_data;
          r_start   <= 1'b1;
          r_valid   <= (r_nw == 13'd1) ? w_last_mask : 8'hFF;
          r_rd_addr <= r_rd_addr + BW'(1);
          r_cnt     <= 13'd1;
        end
        START: if (tx_ack) begin
          r_start <= 1'b0;
          if (r_nw == 13'd1) r_valid <= '0;
          else begin
            r_tx_data <= r_first ? rd_data : r_hold;
            r_valid   <= w_mask;
            r_cnt     <= 13'd2;
            r_rd_addr <= r_rd_addr + BW'(1);
          end
        end
        STREAM: begin
          r_tx_data <= rd_data;
          r_valid   <= w_mask;
          r_cnt     <= w_idx;
          r_rd_addr <= r_rd_addr + BW'(1);
        end
        COMMIT: begin
          r_valid <= '0;
          r_start <= 1'b0;
          r_cons  <= r_cons + r_nw[BW-1:0] + BW'(1);
          r_sent  <= r_sent + 16'd1;
          r_act   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_buff2mac.sv
// tb_buff2mac: directed frames through a buffer model with a scoreboard of expected MAC beats
module tb_buff2mac;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  rd_addr, committed_cons;
  logic [9:0]  prod = '0;
  logic [63:0] rd_data = '0;
  logic [63:0] tx_data;
  logic [7:0]  tx_data_valid;
  logic        tx_start, activity;
  logic        tx_ack = 1'b0;
  logic [15:0] sent_pkts, bad_len_pkts;
  logic [63:0] mem [1024];
  logic [71:0] exp_q [$];
  int checks = 0, passed = 0, act_cnt = 0, wait_cnt = 0, ack_dly = 2;
  bit ack_en = 1'b1;

  buff2mac dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .committed_prod(prod), .committed_cons(committed_cons),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_start(tx_start),
    .tx_ack(tx_ack), .activity(activity), .sent_pkts(sent_pkts),
    .bad_len_pkts(bad_len_pkts)
  );

  always #5 clk = ~clk;

  // buffer read port: data valid one cycle after the registered address
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [7:0] mk(input int len, input int k);
    int b;
    b = len - 8 * (k - 1);
    if (b >= 8) return 8'hFF;
    return 8'((1 << b) - 1);
  endfunction

  task automatic put_frame(input int h, input int len, input logic [15:0] tag);
    int a;
    mem[h] = {16'h0, 16'(len), 32'h0};
    for (int k = 1; k <= (len + 7) / 8; k++) begin
      a = (h + k) % 1024;
      mem[a] = {tag, 16'hBEEF, 16'(a), 16'(k)};
      exp_q.push_back({mk(len, k), mem[a]});
    end
  endtask

  task automatic beat();
    logic [71:0] e;
    if (exp_q.size() == 0) chk("unexpected_beat", {56'h0, tx_data_valid}, 64'h0);
    else begin
      e = exp_q.pop_front();
      chk("beat_data", tx_data, e[63:0]);
      chk("beat_mask", {56'h0, tx_data_valid}, {56'h0, e[71:64]});
    end
  endtask

  // MAC model: consumes word 1 on the ack cycle, then one word per valid cycle
  task automatic tick();
    @(negedge clk);
    if (activity) act_cnt++;
    if (tx_ack) tx_ack = 1'b0;
    if (!tx_start && tx_data_valid != 8'h0) beat();
    else if (tx_start && ack_en) begin
      if (wait_cnt >= ack_dly) begin
        beat();
        tx_ack = 1'b1;
        wait_cnt = 0;
      end else wait_cnt++;
    end
  endtask

  task automatic wait_cons(input logic [9:0] v, input int budget);
    int n = 0;
    while (committed_cons !== v && n < budget) begin
      tick();
      n++;
    end
    chk("cons", {54'h0, committed_cons}, {54'h0, v});
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (tx_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("start_seen", {63'h0, tx_start}, 64'h1);
  endtask

  initial begin
    logic [9:0] a0;
    bit moved;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (3) tick();
    chk("rst_rd_addr", {54'h0, rd_addr}, 64'h0);
    chk("rst_cons", {54'h0, committed_cons}, 64'h0);
    chk("rst_valid", {56'h0, tx_data_valid}, 64'h0);
    chk("rst_start", {63'h0, tx_start}, 64'h0);
    chk("rst_data", tx_data, 64'h0);
    chk("rst_counters", {32'h0, sent_pkts, bad_len_pkts}, 64'h0);
    chk("rst_activity", {63'h0, activity}, 64'h0);
    rst_n = 1'b1;
    put_frame(0, 60, 16'h0001);
    prod = 10'd9;
    wait_cons(10'd9, 100);
    chk("sent_1", {48'h0, sent_pkts}, 64'd1);
    chk("activity_1", 64'(act_cnt), 64'd1);
    chk("drain_1", 64'(exp_q.size()), 64'd0);
    put_frame(9, 64, 16'h0002);
    put_frame(18, 65, 16'h0003);
    prod = 10'd28;
    wait_cons(10'd18, 100);
    wait_cons(10'd28, 100);
    chk("sent_3", {48'h0, sent_pkts}, 64'd3);
    chk("drain_2", 64'(exp_q.size()), 64'd0);
    mem[28] = {16'h0, 16'd0, 32'h0};
    prod = 10'd29;
    wait_cons(10'd29, 20);
    chk("bad_1", {48'h0, bad_len_pkts}, 64'd1);
    mem[29] = {16'h0, 16'd20000, 32'h0};
    prod = 10'd32;
    wait_cons(10'd32, 20);
    chk("bad_2", {48'h0, bad_len_pkts}, 64'd2);
    chk("sent_unchanged", {48'h0, sent_pkts}, 64'd3);
    put_frame(32, 24, 16'h0004);
    ack_en = 1'b0;
    prod = 10'd36;
    wait_start(30);
    a0 = rd_addr;
    moved = 1'b0;
    repeat (50) begin
      tick();
      if (rd_addr !== a0) moved = 1'b1;
    end
    chk("hold_start", {63'h0, tx_start}, 64'h1);
    chk("hold_data", tx_data, mem[33]);
    chk("hold_rd_addr_moved", {63'h0, moved}, 64'h0);
    chk("hold_cons", {54'h0, committed_cons}, 64'd32);
    ack_en = 1'b1;
    wait_cons(10'd36, 100);
    chk("drain_3", 64'(exp_q.size()), 64'd0);
    mem[36] = {16'h0, 16'd20000, 32'h0};
    prod = 10'd1020;
    wait_cons(10'd1020, 20);
    chk("bad_3", {48'h0, bad_len_pkts}, 64'd3);
    put_frame(1020, 100, 16'h0005);
    prod = 10'd10;
    wait_cons(10'd10, 200);
    chk("drain_wrap", 64'(exp_q.size()), 64'd0);
    chk("sent_5", {48'h0, sent_pkts}, 64'd5);
    put_frame(10, 200, 16'h0006);
    ack_dly = 0;
    prod = 10'd36;
    wait_start(30);
    repeat (6) tick();
    chk("mid_stream_valid", {56'h0, tx_data_valid}, 64'hFF);
    rst_n = 1'b0;
    #1;
    chk("async_valid", {56'h0, tx_data_valid}, 64'h0);
    chk("async_start", {63'h0, tx_start}, 64'h0);
    chk("async_cons", {54'h0, committed_cons}, 64'h0);
    exp_q.delete();
    prod = 10'd0;
    wait_cnt = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_cons", {54'h0, committed_cons}, 64'h0);
    chk("post_rst_sent", {48'h0, sent_pkts}, 64'h0);
    put_frame(0, 16, 16'h0007);
    prod = 10'd3;
    wait_cons(10'd3, 100);
    chk("post_rst_frame", {48'h0, sent_pkts}, 64'd1);
    chk("drain_end", 64'(exp_q.size()), 64'd0);
    chk("activity_total", 64'(act_cnt), 64'd6);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
